axi4lite_reg_bridge: RTL and testbench

AXI4LITE_REG_BRIDGE -- requirements
Module: axi4lite_reg_bridge

---
 rtl/axi4lite_pkg.sv | 21 ++
 rtl/axi4lite_reg_bridge.sv | 156 +++++++++++++++
 tb/tb_axi4lite_reg_bridge.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite types: response codes, register-bridge FSM states and access timeout.
package axi4lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    RD_REQ,
    WR_RESP,
    RD_RESP
  } bridge_state_e;

  localparam int REG_TIMEOUT = 16;

endpackage

// File: rtl/axi4lite_reg_bridge.sv
// AXI4-Lite slave to single-outstanding register strobe bus; reg_req one cycle after the last address/data handshake.
// Backpressure: B/R held stable until BREADY/RREADY; unacked accesses end as SLVERR after REG_TIMEOUT cycles.
module axi4lite_reg_bridge
  import axi4lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [2:0]              AWPROT,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [2:0]              ARPROT,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic                    reg_req,
  output logic                    reg_we,
  output logic [ADDR_WIDTH-1:0]   reg_addr,
  output logic [DATA_WIDTH-1:0]   reg_wdata,
  output logic [DATA_WIDTH/8-1:0] reg_wstrb,
  input  logic                    reg_ack,
  input  logic [DATA_WIDTH-1:0]   reg_rdata,
  input  logic                    reg_err
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int TMO_W  = $clog2(REG_TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << LSB;

  bridge_state_e         state, state_nxt;
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q, rdata_q;
  logic [STRB_W-1:0]     w_strb_q;
  axi_resp_e             resp_q;
  logic [TMO_W-1:0]      tmo_cnt;
  logic                  tmo_hit, acc_done, acc_ok;
  logic                  aw_hs, w_hs, ar_hs, b_hs;
  logic                  unused_prot;

  assign unused_prot = ^{AWPROT, ARPROT};

  assign tmo_hit  = (tmo_cnt == TMO_W'(REG_TIMEOUT - 1));
  assign acc_done = reg_req && (reg_ack || tmo_hit);
  assign acc_ok   = reg_ack && !reg_err;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign b_hs  = BVALID && BREADY;

  assign reg_addr  = (state == WR_REQ ? aw_addr_q : ar_addr_q) & ADDR_MASK;
  assign reg_wdata = w_data_q;
  assign reg_wstrb = w_strb_q;
  assign BRESP     = resp_q;
  assign RRESP     = resp_q;
  assign RDATA     = rdata_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    ARREADY   = 1'b0;
    BVALID    = 1'b0;
    RVALID    = 1'b0;
    reg_req   = 1'b0;
    reg_we    = 1'b0;
    case (state)
      IDLE: begin
        AWREADY = ARESETN && !aw_held;
        WREADY  = ARESETN && !w_held;
        // A pending or arriving write blocks reads so the write always goes first
        ARREADY = ARESETN && !aw_held && !w_held && !AWVALID && !WVALID;
        if ((aw_held || aw_hs) && (w_held || w_hs))
          state_nxt = WR_REQ;
        else if (ARVALID && ARREADY)
          state_nxt = RD_REQ;
      end
      WR_REQ: begin
        reg_req = 1'b1;
        reg_we  = 1'b1;
        if (reg_ack || tmo_hit) state_nxt = WR_RESP;
      end
      RD_REQ: begin
        reg_req = 1'b1;
        if (reg_ack || tmo_hit) state_nxt = RD_RESP;
      end
      WR_RESP: begin
        BVALID = 1'b1;
        if (BREADY) state_nxt = IDLE;
      end
      RD_RESP: begin
        RVALID = 1'b1;
        if (RREADY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      rdata_q   <= '0;
      resp_q    <= OKAY;
      tmo_cnt   <= '0;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= AWADDR;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
      if (ar_hs) ar_addr_q <= ARADDR;
      if (b_hs) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      if (reg_req && !acc_done) tmo_cnt <= tmo_cnt + TMO_W'(1);
      else                      tmo_cnt <= '0;
      // ack wins over a same-cycle timeout
      if (acc_done) begin
        resp_q <= acc_ok ? OKAY : SLVERR;
        if (!reg_we) rdata_q <= acc_ok ? reg_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_reg_bridge.sv
// Directed bench for axi4lite_reg_bridge with hand-computed expectations.
module tb_axi4lite_reg_bridge;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic        reg_req;
  logic        reg_we;
  logic [31:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        reg_ack;
  logic [31:0] reg_rdata;
  logic        reg_err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 ACLK = ~ACLK;

  axi4lite_reg_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
    .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // All stimulus changes and samples land 1 time unit after the rising edge
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    AWADDR = a; AWVALID = 1'b1;
    WDATA = d; WSTRB = s; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    ARADDR = a; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
  endtask

  task automatic reg_reply(input logic err, input logic [31:0] rd);
    reg_ack = 1'b1; reg_err = err; reg_rdata = rd;
    tick();
    reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = '0;
  endtask

  task automatic take_b();
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
  endtask

  task automatic take_r();
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ARESETN = 1'b0;
    AWADDR = '0; AWPROT = 3'b010; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARPROT = 3'b001; ARVALID = 1'b0; RREADY = 1'b0;
    reg_ack = 1'b0; reg_rdata = '0; reg_err = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_awready", AWREADY, 0);
    chk("rst_wready",  WREADY, 0);
    chk("rst_arready", ARREADY, 0);
    chk("rst_bvalid",  BVALID, 0);
    chk("rst_rvalid",  RVALID, 0);
    chk("rst_reg_req", reg_req, 0);
    chk("rst_rdata",   RDATA, 0);
    chk("rst_bresp",   BRESP, 0);
    ARESETN = 1'b1;
    tick();
    chk("idle_awready", AWREADY, 1);
    chk("idle_wready",  WREADY, 1);
    chk("idle_arready", ARREADY, 1);

    // AW and W together, ack next cycle
    send_aw_w(32'h10, 32'hDEADBEEF, 4'hF);
    chk("w1_req",     reg_req, 1);
    chk("w1_we",      reg_we, 1);
    chk("w1_addr",    reg_addr, 32'h10);
    chk("w1_wdata",   reg_wdata, 32'hDEADBEEF);
    chk("w1_wstrb",   reg_wstrb, 4'hF);
    chk("w1_awready", AWREADY, 0);
    reg_reply(1'b0, 32'h0);
    chk("w1_req_drop", reg_req, 0);
    chk("w1_bvalid",   BVALID, 1);
    chk("w1_bresp",    BRESP, 2'b00);
    take_b();
    chk("w1_b_done",   BVALID, 0);
    chk("w1_aw_free",  AWREADY, 1);

    // W three cycles ahead of AW
    WDATA = 32'hCAFEF00D; WSTRB = 4'h3; WVALID = 1'b1;
    tick();
    WVALID = 1'b0; WDATA = 32'h0;
    chk("w2_wready_held", WREADY, 0);
    chk("w2_ar_blocked",  ARREADY, 0);
    chk("w2_no_req",      reg_req, 0);
    tick(); tick();
    AWADDR = 32'h14; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    chk("w2_req",     reg_req, 1);
    chk("w2_addr",    reg_addr, 32'h14);
    chk("w2_wdata",   reg_wdata, 32'hCAFEF00D);
    chk("w2_wstrb",   reg_wstrb, 4'h3);
    chk("w2_awready", AWREADY, 0);
    reg_reply(1'b0, 32'h0);
    chk("w2_bvalid",       BVALID, 1);
    chk("w2_awready_resp", AWREADY, 0);
    take_b();
    chk("w2_aw_free", AWREADY, 1);

    // read from unaligned address, RREADY stalled
    send_ar(32'h23);
    chk("r1_req",  reg_req, 1);
    chk("r1_we",   reg_we, 0);
    chk("r1_addr", reg_addr, 32'h20);
    reg_reply(1'b0, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      chk("r1_rvalid_stall", RVALID, 1);
      chk("r1_rdata_stall",  RDATA, 32'h12345678);
      tick();
    end
    chk("r1_rresp", RRESP, 2'b00);
    take_r();
    chk("r1_r_done", RVALID, 0);

    // read error
    send_ar(32'h40);
    reg_reply(1'b1, 32'hFFFFFFFF);
    chk("r2_rvalid", RVALID, 1);
    chk("r2_rresp",  RRESP, 2'b10);
    chk("r2_rdata",  RDATA, 32'h0);
    take_r();

    // write timeout
    send_aw_w(32'h30, 32'h55AA55AA, 4'hF);
    n = 0;
    while (reg_req && n < 40) begin
      n++;
      tick();
    end
    chk("w3_req_cycles", n, 16);
    chk("w3_bvalid",     BVALID, 1);
    chk("w3_bresp",      BRESP, 2'b10);
    take_b();

    // stray ack in IDLE
    reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0;
    chk("stray_req",    reg_req, 0);
    chk("stray_bvalid", BVALID, 0);
    chk("stray_rvalid", RVALID, 0);

    // AR collides with AW+W: write goes first
    AWADDR = 32'h50; AWVALID = 1'b1;
    WDATA = 32'h01020304; WSTRB = 4'hF; WVALID = 1'b1;
    ARADDR = 32'h60; ARVALID = 1'b1;
    #1;
    chk("col_arready", ARREADY, 0);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("col_w_we",   reg_we, 1);
    chk("col_w_addr", reg_addr, 32'h50);
    reg_reply(1'b0, 32'h0);
    chk("col_bvalid", BVALID, 1);
    take_b();
    chk("col_arready_after", ARREADY, 1);
    tick();
    ARVALID = 1'b0;
    chk("col_r_req",  reg_req, 1);
    chk("col_r_we",   reg_we, 0);
    chk("col_r_addr", reg_addr, 32'h60);
    reg_reply(1'b0, 32'h0000A5A5);
    chk("col_rdata", RDATA, 32'h0000A5A5);
    take_r();

    // reset pulse in the middle of a write access
    send_aw_w(32'h70, 32'h77777777, 4'hF);
    chk("rw_req", reg_req, 1);
    #2;
    ARESETN = 1'b0;
    #1;
    chk("rw_req_drop",  reg_req, 0);
    chk("rw_awready",   AWREADY, 0);
    chk("rw_wready",    WREADY, 0);
    chk("rw_bvalid",    BVALID, 0);
    chk("rw_reg_addr",  reg_addr, 32'h0);
    chk("rw_reg_wdata", reg_wdata, 32'h0);
    tick();
    ARESETN = 1'b1;
    reg_ack = 1'b1;
    tick(); tick();
    reg_ack = 1'b0;
    chk("rw_no_bvalid", BVALID, 0);
    chk("rw_no_req",    reg_req, 0);
    chk("rw_idle_aw",   AWREADY, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
